// File: rtl/cajero_pkg.sv
// Shared definitions for the Cajero customer-side driver.
// Contents: FSM state encoding, result code constants, transaction type
// values and a helper that resolves simultaneous PIN rejection flags.
package cajero_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARJETA,
    ST_DIGITOS,
    ST_ESPERA_PIN,
    ST_MONTO,
    ST_ESPERA_FIN,
    ST_REPORTE
  } estado_t;

  localparam logic [2:0] RES_DEP_OK     = 3'd0;
  localparam logic [2:0] RES_RET_OK     = 3'd1;
  localparam logic [2:0] RES_FONDOS_INS = 3'd2;
  localparam logic [2:0] RES_PIN_INC    = 3'd3;
  localparam logic [2:0] RES_PIN_ADV    = 3'd4;
  localparam logic [2:0] RES_BLOQ       = 3'd5;
  localparam logic [2:0] RES_TIMEOUT    = 3'd6;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  // Blocking outranks the warning, which outranks a plain wrong PIN.
  function automatic logic [2:0] codigo_rechazo(input logic bloq, input logic adv);
    if (bloq)     return RES_BLOQ;
    else if (adv) return RES_PIN_ADV;
    else          return RES_PIN_INC;
  endfunction

endpackage

// File: rtl/terminal_cliente.sv
// terminal_cliente: initiator end of the Cajero card/keypad/amount interface.
// Takes one command (PIN, type, amount), plays it into Cajero as a card
// insertion, four strobed PIN digits and a strobed amount, then watches the
// Cajero status lines and returns one result code plus the updated balance.
//
// Ports:
//   CLK, RESET                    clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY           command handshake
//   CMD_PIN[15:0]                 four BCD digits, [15:12] sent first
//   CMD_TIPO, CMD_MONTO[31:0]     type (0 deposit, 1 withdrawal), amount
//   TARJETA_RECIBIDA              card-present level to Cajero
//   DIGITO_STB, DIGITO[3:0]       digit strobe and value
//   TIPO_TRANS, MONTO_STB, MONTO  amount phase to Cajero
//   BALANCE_ACTUALIZADO[63:0]     balance from Cajero
//   BALANCE_STB .. BLOQUEO        Cajero status inputs
//   RES_VALID, RES_CODE, RES_BALANCE  result pulse, code and balance
import cajero_pkg::*;

module terminal_cliente #(
  parameter int GAP_CICLOS = 1,
  parameter int PIN_ESPERA = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_PIN,
  input  logic        CMD_TIPO,
  input  logic [31:0] CMD_MONTO,
  output logic        TARJETA_RECIBIDA,
  output logic        DIGITO_STB,
  output logic [3:0]  DIGITO,
  output logic        TIPO_TRANS,
  output logic        MONTO_STB,
  output logic [31:0] MONTO,
  input  logic [63:0] BALANCE_ACTUALIZADO,
  input  logic        BALANCE_STB,
  input  logic        ENTREGAR_DINERO,
  input  logic        FONDOS_INSUFICIENTES,
  input  logic        PIN_INCORRECTO,
  input  logic        ADVERTENCIA,
  input  logic        BLOQUEO,
  output logic        RES_VALID,
  output logic [2:0]  RES_CODE,
  output logic [63:0] RES_BALANCE
);

  estado_t     state_q, state_d;
  logic [15:0] pin_q;
  logic        tipo_q;
  logic [31:0] monto_q;
  logic [1:0]  dig_q, dig_d;
  logic [15:0] cnt_q, cnt_d;   // digit gap, then PIN_ESPERA window
  logic [15:0] to_q, to_d;     // cycles spent in ESPERA_FIN
  logic        bal_seen_q, bal_seen_d;
  logic        ent_seen_q, ent_seen_d;
  logic [63:0] bal_q, bal_d;
  logic [2:0]  res_code_q, res_code_d;
  logic [63:0] res_bal_q, res_bal_d;

  logic        cmd_hs;
  logic        rechazo;
  logic        bal_now, ent_now;
  logic [3:0]  nibble;

  assign cmd_hs  = CMD_VALID & CMD_READY;
  assign rechazo = BLOQUEO | ADVERTENCIA | PIN_INCORRECTO;

  always_comb begin
    case (dig_q)
      2'd0:    nibble = pin_q[15:12];
      2'd1:    nibble = pin_q[11:8];
      2'd2:    nibble = pin_q[7:4];
      default: nibble = pin_q[3:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    bal_seen_d = bal_seen_q;
    ent_seen_d = ent_seen_q;
    bal_d      = bal_q;
    res_code_d = res_code_q;
    res_bal_d  = res_bal_q;
    bal_now    = bal_seen_q | BALANCE_STB;
    ent_now    = ent_seen_q | ENTREGAR_DINERO;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          state_d    = ST_TARJETA;
          dig_d      = '0;
          cnt_d      = '0;
          to_d       = '0;
          bal_seen_d = 1'b0;
          ent_seen_d = 1'b0;
          bal_d      = '0;
        end
      end
      ST_TARJETA: state_d = ST_DIGITOS;
      ST_DIGITOS: begin
        // Rejections are honoured from the 4th strobe onward.
        if (dig_q == 2'd3 && rechazo) begin
          state_d    = ST_REPORTE;
          res_code_d = codigo_rechazo(BLOQUEO, ADVERTENCIA);
          res_bal_d  = '0;
        end else if (cnt_q == 16'(GAP_CICLOS)) begin
          cnt_d = '0;
          if (dig_q == 2'd3) state_d = ST_ESPERA_PIN;
          else               dig_d   = dig_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ESPERA_PIN: begin
        // Window is PIN_ESPERA cycles plus one, so MONTO_STB lands
        // (gap+1)+PIN_ESPERA+1 cycles after the last digit strobe.
        if (rechazo) begin
          state_d    = ST_REPORTE;
          res_code_d = codigo_rechazo(BLOQUEO, ADVERTENCIA);
          res_bal_d  = '0;
        end else if (cnt_q == 16'(PIN_ESPERA)) begin
          state_d = ST_MONTO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_MONTO: state_d = ST_ESPERA_FIN;
      ST_ESPERA_FIN: begin
        bal_seen_d = bal_now;
        ent_seen_d = ent_now;
        to_d       = to_q + 16'd1;
        if (BALANCE_STB) bal_d = BALANCE_ACTUALIZADO;
        if (rechazo) begin
          state_d    = ST_REPORTE;
          res_code_d = codigo_rechazo(BLOQUEO, ADVERTENCIA);
          res_bal_d  = '0;
        end else if (FONDOS_INSUFICIENTES) begin
          state_d    = ST_REPORTE;
          res_code_d = RES_FONDOS_INS;
          res_bal_d  = '0;
        end else if (tipo_q == TIPO_DEPOSITO && BALANCE_STB) begin
          state_d    = ST_REPORTE;
          res_code_d = RES_DEP_OK;
          res_bal_d  = BALANCE_ACTUALIZADO;
        end else if (tipo_q == TIPO_RETIRO && bal_now && ent_now) begin
          // Balance may have arrived earlier than the cash-out strobe.
          state_d    = ST_REPORTE;
          res_code_d = RES_RET_OK;
          res_bal_d  = BALANCE_STB ? BALANCE_ACTUALIZADO : bal_q;
        end else if (to_q == 16'(TIMEOUT - 1)) begin
          state_d    = ST_REPORTE;
          res_code_d = RES_TIMEOUT;
          res_bal_d  = '0;
        end
      end
      ST_REPORTE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pin_q      <= '0;
      tipo_q     <= 1'b0;
      monto_q    <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      bal_seen_q <= 1'b0;
      ent_seen_q <= 1'b0;
      bal_q      <= '0;
      res_code_q <= '0;
      res_bal_q  <= '0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      bal_seen_q <= bal_seen_d;
      ent_seen_q <= ent_seen_d;
      bal_q      <= bal_d;
      res_code_q <= res_code_d;
      res_bal_q  <= res_bal_d;
      if (cmd_hs) begin
        pin_q   <= CMD_PIN;
        tipo_q  <= CMD_TIPO;
        monto_q <= CMD_MONTO;
      end
    end
  end

  // Outputs decode straight from the state register, so RESET clears them
  // without waiting for a clock edge.
  logic fase_monto;
  assign fase_monto = (state_q == ST_MONTO) || (state_q == ST_ESPERA_FIN) ||
                      (state_q == ST_REPORTE);

  assign CMD_READY        = (state_q == ST_IDLE);
  assign TARJETA_RECIBIDA = (state_q == ST_TARJETA) || (state_q == ST_DIGITOS) ||
                            (state_q == ST_ESPERA_PIN) || (state_q == ST_MONTO) ||
                            (state_q == ST_ESPERA_FIN);
  assign DIGITO_STB       = (state_q == ST_DIGITOS) && (cnt_q == 16'd0);
  assign DIGITO           = DIGITO_STB ? nibble : 4'd0;
  assign MONTO_STB        = (state_q == ST_MONTO);
  assign TIPO_TRANS       = fase_monto ? tipo_q : 1'b0;
  assign MONTO            = fase_monto ? monto_q : 32'd0;
  assign RES_VALID        = (state_q == ST_REPORTE);
  assign RES_CODE         = res_code_q;
  assign RES_BALANCE      = res_bal_q;

endmodule

// File: tb/tb_terminal_cliente.sv
// Bench for terminal_cliente. The main thread issues commands and plays the
// Cajero side; an account model decides each outcome and pushes the expected
// result into a queue; a monitor pops and compares on every RES_VALID.
// Time is expressed as the index of the rising edge at which a signal is
// sampled: a value seen at a falling edge is sampled at edge cyc+1.
`timescale 1ns/1ps
module tb_terminal_cliente;
  localparam int G = 1;
  localparam int P = 4;
  localparam int T = 64;
  localparam logic [15:0] PIN_OK = 16'h1234;

  localparam int K_DEP = 0, K_RET = 1, K_FONDOS = 2, K_REJ = 3,
                 K_SILENT = 4, K_FONDOS_BAL = 5, K_LATE = 6;

  logic        CLK = 0, RESET = 1;
  logic        CMD_VALID = 0, CMD_READY, CMD_TIPO = 0;
  logic [15:0] CMD_PIN = 0;
  logic [31:0] CMD_MONTO = 0;
  logic        TARJETA_RECIBIDA, DIGITO_STB, TIPO_TRANS, MONTO_STB;
  logic [3:0]  DIGITO;
  logic [31:0] MONTO;
  logic [63:0] BALANCE_ACTUALIZADO = 0;
  logic        BALANCE_STB = 0, ENTREGAR_DINERO = 0, FONDOS_INSUFICIENTES = 0;
  logic        PIN_INCORRECTO = 0, ADVERTENCIA = 0, BLOQUEO = 0;
  logic        RES_VALID;
  logic [2:0]  RES_CODE;
  logic [63:0] RES_BALANCE;

  terminal_cliente #(.GAP_CICLOS(G), .PIN_ESPERA(P), .TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_PIN(CMD_PIN), .CMD_TIPO(CMD_TIPO), .CMD_MONTO(CMD_MONTO),
    .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO),
    .TIPO_TRANS(TIPO_TRANS), .MONTO_STB(MONTO_STB), .MONTO(MONTO),
    .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .BALANCE_STB(BALANCE_STB),
    .ENTREGAR_DINERO(ENTREGAR_DINERO), .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
    .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .RES_VALID(RES_VALID), .RES_CODE(RES_CODE), .RES_BALANCE(RES_BALANCE));

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [2:0] code; logic [63:0] bal; } res_t;
  res_t exp_q[$];

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (RES_VALID) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_res: RES_VALID with nothing pending, code %0d", RES_CODE);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("res_code", 64'(RES_CODE), 64'(r.code));
        chk("res_balance", RES_BALANCE, r.bal);
      end
    end
  end

  // Account model: what Cajero would do with this command.
  logic [63:0] bal_m;
  int          fails;

  task automatic clr_inputs();
    BALANCE_STB = 0; ENTREGAR_DINERO = 0; FONDOS_INSUFICIENTES = 0;
    PIN_INCORRECTO = 0; ADVERTENCIA = 0; BLOQUEO = 0;
    BALANCE_ACTUALIZADO = {$urandom, $urandom};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(CMD_READY), 1);
    chk({tag, "_tarjeta"}, 64'(TARJETA_RECIBIDA), 0);
    chk({tag, "_dstb"}, 64'(DIGITO_STB), 0);
    chk({tag, "_digito"}, 64'(DIGITO), 0);
    chk({tag, "_mstb"}, 64'(MONTO_STB), 0);
    chk({tag, "_monto"}, 64'(MONTO), 0);
    chk({tag, "_tipo"}, 64'(TIPO_TRANS), 0);
    chk({tag, "_rvalid"}, 64'(RES_VALID), 0);
    chk({tag, "_rcode"}, 64'(RES_CODE), 0);
    chk({tag, "_rbal"}, RES_BALANCE, 0);
  endtask

  task automatic run_txn(input logic [15:0] pin, input logic tipo, input logic [31:0] amt,
                         input bit silent, input bit late, input bit both, input bit abort);
    int          kind;
    logic [2:0]  f;       // {bloq, adv, inc}
    logic [2:0]  code;
    logic [63:0] rbal, newbal;
    longint      t0, samp, last_stb, m_edge, ev_edge;
    int          ndig, d_rej, d1, d2, order, nstb;
    bit          done, got;
    f = 0; newbal = 0; rbal = 0;
    if (pin != PIN_OK) begin
      kind = K_REJ;
      fails++;
      if (fails == 1)      begin f = 3'b001; code = 3; end
      else if (fails == 2) begin f = 3'b010 | 3'($urandom_range(0, 1)); code = 4; end
      else                 begin f = 3'b100 | 3'($urandom_range(0, 3)); code = 5; fails = 0; end
    end else begin
      fails = 0;
      if (silent) begin kind = K_SILENT; code = 6; end
      else if (late) begin
        kind = K_LATE; f = 3'($urandom_range(1, 7));
        code = f[2] ? 3'd5 : (f[1] ? 3'd4 : 3'd3);
      end else if (tipo == 1'b0) begin
        kind = K_DEP; newbal = bal_m + 64'(amt); code = 0; rbal = newbal; bal_m = newbal;
      end else if (64'(amt) > bal_m) begin
        kind = both ? K_FONDOS_BAL : K_FONDOS; code = 2; newbal = bal_m;
      end else begin
        kind = K_RET; newbal = bal_m - 64'(amt); code = 1; rbal = newbal; bal_m = newbal;
      end
    end
    if (!abort) exp_q.push_back('{code: code, bal: rbal});

    // Handshake
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin got = 1; break; end
    end
    chk("cmd_ready", 64'(got), 1);
    CMD_VALID = 1; CMD_PIN = pin; CMD_TIPO = tipo; CMD_MONTO = amt;
    t0 = cyc + 1;
    @(negedge CLK);
    CMD_VALID = 0; CMD_PIN = 16'($urandom); CMD_TIPO = 1'($urandom); CMD_MONTO = $urandom;
    chk("tarjeta_rise", 64'(TARJETA_RECIBIDA), 1);

    d_rej = $urandom_range(0, 4); d1 = $urandom_range(0, 5);
    d2 = $urandom_range(1, 3); order = $urandom_range(0, 1);
    ndig = 0; last_stb = -1; m_edge = -1; ev_edge = -1; done = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge CLK);
      samp = cyc + 1;
      clr_inputs();
      if (RES_VALID) begin
        if (ev_edge >= 0) chk("res_latency", 64'(samp), 64'(ev_edge + 1));
        chk("tarjeta_drop", 64'(TARJETA_RECIBIDA), 0);
        done = 1; break;
      end
      if (DIGITO_STB) begin
        chk("digit_val", 64'(DIGITO), 64'(pin[15 - 4*ndig -: 4]));
        chk("digit_time", 64'(samp), 64'(t0 + 2 + ndig*(G+1)));
        ndig++;
        if (ndig == 4) last_stb = samp;
        if (abort && ndig == 3) begin
          #2 RESET = 1;
          #1 chk_reset_outputs("abort");
          @(negedge CLK); RESET = 0;
          nstb = 0;
          for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (DIGITO_STB || MONTO_STB || RES_VALID || TARJETA_RECIBIDA) nstb++;
          end
          chk("abort_quiet", 64'(nstb), 0);
          done = 1; break;
        end
      end
      if (kind == K_REJ && last_stb >= 0 && samp == last_stb + d_rej) begin
        {BLOQUEO, ADVERTENCIA, PIN_INCORRECTO} = f;
        ev_edge = samp;
      end
      if (MONTO_STB) begin
        if (kind == K_REJ) chk("no_monto_on_reject", 64'(MONTO_STB), 0);
        else begin
          chk("monto_time", 64'(samp), 64'(last_stb + G + 1 + P + 1));
          chk("monto_val", 64'(MONTO), 64'(amt));
          chk("tipo_val", 64'(TIPO_TRANS), 64'(tipo));
        end
        m_edge = samp;
        if (kind == K_SILENT) ev_edge = m_edge + T;
      end
      if (m_edge >= 0 && kind != K_REJ) begin
        if (samp == m_edge + 1 + d1) begin
          case (kind)
            K_DEP:        begin BALANCE_STB = 1; BALANCE_ACTUALIZADO = newbal; ev_edge = samp; end
            K_RET:        if (order == 0) begin BALANCE_STB = 1; BALANCE_ACTUALIZADO = newbal; end
                          else ENTREGAR_DINERO = 1;
            K_FONDOS:     begin FONDOS_INSUFICIENTES = 1; ev_edge = samp; end
            K_FONDOS_BAL: begin FONDOS_INSUFICIENTES = 1; BALANCE_STB = 1;
                                BALANCE_ACTUALIZADO = newbal; ev_edge = samp; end
            K_LATE:       begin {BLOQUEO, ADVERTENCIA, PIN_INCORRECTO} = f; ev_edge = samp; end
            default: ;
          endcase
        end
        if (kind == K_RET && samp == m_edge + 1 + d1 + d2) begin
          if (order == 0) ENTREGAR_DINERO = 1;
          else begin BALANCE_STB = 1; BALANCE_ACTUALIZADO = newbal; end
          ev_edge = samp;
        end
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL txn_budget: no RES_VALID within 400 cycles, got 0 expected 1");
    end
  endtask

  initial begin
    logic [15:0] p;
    clr_inputs();
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    RESET = 0;
    bal_m = 1000; fails = 0;

    run_txn(PIN_OK, 1'b0, 500, 0, 0, 0, 0);   // deposit -> 1500
    bal_m = 1000;
    run_txn(PIN_OK, 1'b1, 300, 0, 0, 0, 0);   // withdrawal -> 700
    bal_m = 1000;
    run_txn(PIN_OK, 1'b1, 2000, 0, 0, 0, 0);  // insufficient funds
    run_txn(16'h9999, 1'b0, 10, 0, 0, 0, 0);  // codes 3, 4, 5
    run_txn(16'h9999, 1'b0, 10, 0, 0, 0, 0);
    run_txn(16'h9999, 1'b1, 10, 0, 0, 0, 0);
    run_txn(PIN_OK, 1'b0, 77, 1, 0, 0, 0);    // no answer -> timeout
    run_txn(PIN_OK, 1'b0, 42, 0, 0, 0, 1);    // reset during 3rd digit
    run_txn(PIN_OK, 1'b0, 42, 0, 0, 0, 0);    // normal run afterwards
    run_txn(PIN_OK, 1'b1, 5000, 0, 0, 1, 0);  // funds + balance same cycle

    for (int i = 0; i < 30; i++) begin
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : PIN_OK;
      if (p == 16'h1234 && $urandom_range(0, 1) == 0) p = 16'h4321;
      run_txn(p, 1'($urandom), 32'($urandom_range(0, 3000)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              1'($urandom), 0);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL pending_results: %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
